// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and opcode constants for the multi-cycle RV32I control sequencer.
package multicycle_ctrl_fsm_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

    // Widest legal store width (SW); SB/SH/SW are 0..2.
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_BRANCH,
        PC_ALUOUT
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    typedef enum logic [1:0] {
        SRC_RS1,
        SRC_PC,
        SRC_ZERO
    } alu_src_a_e;

    typedef enum logic [2:0] {
        ALU_MEM_ADDR,
        ALU_BRANCH,
        ALU_LUI,
        ALU_JUMP,
        ALU_RTYPE,
        ALU_ITYPE_ARITH
    } alu_op_class_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode/funct3 classifier feeding the control sequencer.
module ctrl_opcode_decode
    import multicycle_ctrl_fsm_pkg::*;
(
    input  logic [6:0]    opcode_i,
    input  logic [2:0]    funct3_i,
    output alu_op_class_e alu_op_class_o,
    output imm_sel_e      imm_sel_o,
    output logic          is_load_o,
    output logic          is_store_o,
    output logic          is_branch_o,
    output logic          is_jump_o,
    output logic          is_pc_rel_o,
    output logic          is_lui_o,
    output logic          use_imm_o,
    output logic          illegal_o
);

    always_comb begin
        alu_op_class_o = ALU_MEM_ADDR;
        imm_sel_o      = IMM_I;
        is_load_o      = 1'b0;
        is_store_o     = 1'b0;
        is_branch_o    = 1'b0;
        is_jump_o      = 1'b0;
        is_pc_rel_o    = 1'b0;
        is_lui_o       = 1'b0;
        use_imm_o      = 1'b0;
        illegal_o      = 1'b0;
        case (opcode_i)
            OPC_LOAD: begin
                is_load_o = 1'b1;
                use_imm_o = 1'b1;
            end
            OPC_STORE: begin
                is_store_o = 1'b1;
                use_imm_o  = 1'b1;
                imm_sel_o  = IMM_S;
                illegal_o  = (funct3_i > F3_SW);
            end
            OPC_BRANCH: begin
                is_branch_o    = 1'b1;
                alu_op_class_o = ALU_BRANCH;
                imm_sel_o      = IMM_B;
            end
            OPC_LUI: begin
                is_lui_o       = 1'b1;
                use_imm_o      = 1'b1;
                alu_op_class_o = ALU_LUI;
                imm_sel_o      = IMM_U;
            end
            OPC_AUIPC: begin
                is_pc_rel_o    = 1'b1;
                use_imm_o      = 1'b1;
                alu_op_class_o = ALU_JUMP;
                imm_sel_o      = IMM_U;
            end
            OPC_JAL: begin
                is_jump_o      = 1'b1;
                is_pc_rel_o    = 1'b1;
                use_imm_o      = 1'b1;
                alu_op_class_o = ALU_JUMP;
                imm_sel_o      = IMM_J;
            end
            OPC_JALR: begin
                is_jump_o      = 1'b1;
                use_imm_o      = 1'b1;
                alu_op_class_o = ALU_JUMP;
            end
            OPC_RTYPE: begin
                alu_op_class_o = ALU_RTYPE;
            end
            OPC_ITYPE: begin
                use_imm_o      = 1'b1;
                alu_op_class_o = ALU_ITYPE_ARITH;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main multi-cycle RV32I sequencer: FSM, memory watchdog and datapath control decode.
//   state  | meaning
//   FETCH  | read instruction at PC, latch into IR on ready
//   DECODE | classify opcode, select immediate, trap if illegal
//   EXEC   | ALU operation; branches resolve and retire here
//   MEM    | load/store data access at ALUOUT; stores retire here
//   WB     | register write-back and PC update; retire
//   TRAP   | halted until reset
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       branch_taken_i,
    input  logic       mem_ready_i,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_addr_sel_o,
    output logic       reg_we_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] alu_src_a_o,
    output logic       alu_src_b_o,
    output logic [2:0] alu_op_class_o,
    output logic [2:0] imm_sel_o,
    output logic       retire_o,
    output logic       trap_o,
    output logic       trap_cause_o
);

    localparam int              TO_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    ctrl_state_e     r_state;
    ctrl_state_e     w_state_nxt;
    logic [TO_W-1:0] r_wd_cnt;
    logic            r_trap;
    logic            r_trap_cause;

    alu_op_class_e   w_dec_class;
    imm_sel_e        w_dec_imm;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_branch;
    logic            w_is_jump;
    logic            w_is_pc_rel;
    logic            w_is_lui;
    logic            w_use_imm;
    logic            w_illegal;

    logic            w_mem_access;
    logic            w_ir_we;
    logic            w_wait;
    logic            w_wd_expire;

    ctrl_opcode_decode u_decode (
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .alu_op_class_o (w_dec_class),
        .imm_sel_o      (w_dec_imm),
        .is_load_o      (w_is_load),
        .is_store_o     (w_is_store),
        .is_branch_o    (w_is_branch),
        .is_jump_o      (w_is_jump),
        .is_pc_rel_o    (w_is_pc_rel),
        .is_lui_o       (w_is_lui),
        .use_imm_o      (w_use_imm),
        .illegal_o      (w_illegal)
    );

    assign w_mem_access = (r_state == FETCH) || (r_state == MEM);
    assign w_wait       = w_mem_access && !mem_ready_i;
    assign w_wd_expire  = (MEM_TIMEOUT > 0) && w_wait && (r_wd_cnt == TO_LAST);

    // FETCH is the reset state, so request/IR strobe are masked while rst_n is low.
    assign mem_req_o    = w_mem_access && rst_n;
    assign ir_we_o      = w_ir_we && rst_n;
    assign trap_o       = r_trap;
    assign trap_cause_o = r_trap_cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt     <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 1'b0;
        end else begin
            if (w_wait && (w_state_nxt == r_state)) begin
                r_wd_cnt <= r_wd_cnt + TO_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end
            if ((w_state_nxt == TRAP) && (r_state != TRAP)) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_wd_expire;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ir_we        = 1'b0;
        pc_we_o        = 1'b0;
        pc_sel_o       = PC_PLUS4;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        reg_we_o       = 1'b0;
        wb_sel_o       = WB_ALU;
        alu_src_a_o    = SRC_RS1;
        alu_src_b_o    = 1'b0;
        alu_op_class_o = ALU_MEM_ADDR;
        imm_sel_o      = IMM_I;
        retire_o       = 1'b0;
        case (r_state)
            FETCH: begin
                if (mem_ready_i) begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = DECODE;
                end else if (w_wd_expire) begin
                    w_state_nxt = TRAP;
                end
            end
            DECODE: begin
                imm_sel_o   = w_dec_imm;
                w_state_nxt = w_illegal ? TRAP : EXEC;
            end
            EXEC: begin
                imm_sel_o      = w_dec_imm;
                alu_op_class_o = w_dec_class;
                alu_src_b_o    = w_use_imm;
                if (w_is_pc_rel) begin
                    alu_src_a_o = SRC_PC;
                end else if (w_is_lui) begin
                    alu_src_a_o = SRC_ZERO;
                end
                if (w_is_branch) begin
                    pc_we_o     = 1'b1;
                    pc_sel_o    = branch_taken_i ? PC_BRANCH : PC_PLUS4;
                    retire_o    = 1'b1;
                    w_state_nxt = FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = MEM;
                end else begin
                    w_state_nxt = WB;
                end
            end
            MEM: begin
                imm_sel_o      = w_dec_imm;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = w_is_store;
                if (mem_ready_i) begin
                    if (w_is_store) begin
                        pc_we_o     = 1'b1;
                        retire_o    = 1'b1;
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = WB;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = TRAP;
                end
            end
            WB: begin
                imm_sel_o   = w_dec_imm;
                reg_we_o    = 1'b1;
                pc_we_o     = 1'b1;
                retire_o    = 1'b1;
                w_state_nxt = FETCH;
                if (w_is_load) begin
                    wb_sel_o = WB_MEM;
                end else if (w_is_jump) begin
                    wb_sel_o = WB_PC4;
                    pc_sel_o = PC_ALUOUT;
                end
            end
            TRAP: begin
                w_state_nxt = TRAP;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm; one task per scenario.
module tb_multicycle_ctrl_fsm;
    import multicycle_ctrl_fsm_pkg::*;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_RTYPE  = 7'b0110011;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode_i = T_RTYPE;
    logic [2:0] funct3_i = 3'd0;
    logic       branch_taken_i = 1'b0;
    logic       mem_ready_i = 1'b1;
    logic       ir_we_o, pc_we_o, mem_req_o, mem_we_o, mem_addr_sel_o, reg_we_o;
    logic       alu_src_b_o, retire_o, trap_o, trap_cause_o;
    logic [1:0] pc_sel_o, wb_sel_o, alu_src_a_o;
    logic [2:0] alu_op_class_o, imm_sel_o;

    int errors = 0;
    int checks = 0;

    // {mem_req, ir_we, pc_we, reg_we, retire, mem_addr_sel, mem_we}
    wire [6:0] w_ctl = {mem_req_o, ir_we_o, pc_we_o, reg_we_o, retire_o, mem_addr_sel_o, mem_we_o};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .branch_taken_i (branch_taken_i),
        .mem_ready_i    (mem_ready_i),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_sel_o (mem_addr_sel_o),
        .reg_we_o       (reg_we_o),
        .wb_sel_o       (wb_sel_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_class_o (alu_op_class_o),
        .imm_sel_o      (imm_sel_o),
        .retire_o       (retire_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o)
    );

    // Every task starts just after a falling edge with the DUT in the first FETCH cycle.
    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst_n = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i = T_RTYPE;
        repeat (2) @(negedge clk);
        #1;
        obs = {w_ctl, trap_o, trap_cause_o, pc_sel_o, wb_sel_o, alu_src_a_o, alu_src_b_o,
               alu_op_class_o, imm_sel_o};
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [6:0] exp_ctl [1:4];
        exp_ctl = '{7'b1100000, 7'b0000000, 7'b0000000, 7'b0011100};
        opcode_i = T_RTYPE;
        funct3_i = 3'd0;
        mem_ready_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++;
            if (w_ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL add_ctl c%0d: got %b expected %b", c, w_ctl, exp_ctl[c]);
            end
            if (c == 3) begin
                checks++;
                if ({alu_op_class_o, alu_src_a_o, alu_src_b_o} !== {3'd4, 2'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL add_exec: got cls=%0d a=%0d b=%0d expected 4 0 0",
                             alu_op_class_o, alu_src_a_o, alu_src_b_o);
                end
            end
            if (c == 4) begin
                checks++;
                if ({wb_sel_o, pc_sel_o, trap_o} !== {2'd0, 2'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL add_wb: got wb=%0d pc_sel=%0d trap=%0d expected 0 0 0",
                             wb_sel_o, pc_sel_o, trap_o);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_wait();
        logic [6:0] exp_ctl [1:7];
        logic       rdy [1:7];
        exp_ctl = '{7'b1100000, 7'b0, 7'b0, 7'b1000010, 7'b1000010, 7'b1000010, 7'b0011100};
        rdy     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode_i = T_LOAD;
        funct3_i = 3'b010;
        for (int c = 1; c <= 7; c++) begin
            mem_ready_i = rdy[c];
            #1;
            checks++;
            if (w_ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL lw_ctl c%0d: got %b expected %b", c, w_ctl, exp_ctl[c]);
            end
            if (c == 3) begin
                checks++;
                if ({alu_op_class_o, alu_src_b_o, imm_sel_o} !== {3'd0, 1'b1, 3'd0}) begin
                    errors++;
                    $display("FAIL lw_exec: got cls=%0d b=%0d imm=%0d expected 0 1 0",
                             alu_op_class_o, alu_src_b_o, imm_sel_o);
                end
            end
            if (c == 7) begin
                checks++;
                if ({wb_sel_o, pc_sel_o} !== {2'd1, 2'd0}) begin
                    errors++;
                    $display("FAIL lw_wb: got wb=%0d pc_sel=%0d expected 1 0", wb_sel_o, pc_sel_o);
                end
            end
            @(negedge clk);
        end
        mem_ready_i = 1'b1;
    endtask

    task automatic test_store();
        logic [6:0] exp_ctl [1:4];
        exp_ctl = '{7'b1100000, 7'b0, 7'b0, 7'b1010111};
        opcode_i = T_STORE;
        funct3_i = 3'b010;
        mem_ready_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++;
            if (w_ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL sw_ctl c%0d: got %b expected %b", c, w_ctl, exp_ctl[c]);
            end
            if (c == 2) begin
                checks++;
                if (imm_sel_o !== 3'd1) begin
                    errors++;
                    $display("FAIL sw_imm: got %0d expected 1", imm_sel_o);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch(input logic taken);
        logic [6:0] exp_ctl [1:3];
        exp_ctl = '{7'b1100000, 7'b0, 7'b0010100};
        opcode_i = T_BRANCH;
        funct3_i = 3'b000;
        branch_taken_i = taken;
        mem_ready_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if (w_ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL beq_ctl taken=%0d c%0d: got %b expected %b", taken, c, w_ctl, exp_ctl[c]);
            end
            if (c == 3) begin
                checks++;
                if ({pc_sel_o, alu_op_class_o, imm_sel_o} !== {(taken ? 2'd1 : 2'd0), 3'd1, 3'd2}) begin
                    errors++;
                    $display("FAIL beq_exec taken=%0d: got pc_sel=%0d cls=%0d imm=%0d expected %0d 1 2",
                             taken, pc_sel_o, alu_op_class_o, imm_sel_o, taken ? 1 : 0);
                end
            end
            @(negedge clk);
        end
        branch_taken_i = 1'b0;
    endtask

    task automatic test_jal();
        logic [6:0] exp_ctl [1:4];
        exp_ctl = '{7'b1100000, 7'b0, 7'b0, 7'b0011100};
        opcode_i = T_JAL;
        funct3_i = 3'b000;
        mem_ready_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++;
            if (w_ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL jal_ctl c%0d: got %b expected %b", c, w_ctl, exp_ctl[c]);
            end
            if (c == 3) begin
                checks++;
                if ({alu_src_a_o, alu_op_class_o, alu_src_b_o, imm_sel_o} !== {2'd1, 3'd3, 1'b1, 3'd4}) begin
                    errors++;
                    $display("FAIL jal_exec: got a=%0d cls=%0d b=%0d imm=%0d expected 1 3 1 4",
                             alu_src_a_o, alu_op_class_o, alu_src_b_o, imm_sel_o);
                end
            end
            if (c == 4) begin
                checks++;
                if ({wb_sel_o, pc_sel_o} !== {2'd2, 2'd2}) begin
                    errors++;
                    $display("FAIL jal_wb: got wb=%0d pc_sel=%0d expected 2 2", wb_sel_o, pc_sel_o);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal(input logic [6:0] opc, input logic [2:0] f3);
        opcode_i = opc;
        funct3_i = f3;
        mem_ready_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++;
            if ({w_ctl, trap_o, trap_cause_o} !== {(c == 1) ? 7'b1100000 : 7'b0, (c >= 3), 1'b0}) begin
                errors++;
                $display("FAIL illegal opc=%b f3=%0d c%0d: got ctl=%b trap=%0d cause=%0d expected trap=%0d cause=0",
                         opc, f3, c, w_ctl, trap_o, trap_cause_o, (c >= 3));
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, trap_o} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_reset: got req=%0d trap=%0d expected 0 0", mem_req_o, trap_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        opcode_i = T_RTYPE;
    endtask

    task automatic test_timeout();
        opcode_i = T_RTYPE;
        mem_ready_i = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            #1;
            checks++;
            if ({w_ctl, trap_o, trap_cause_o} !== {(c <= 16) ? 7'b1000000 : 7'b0, (c >= 17), (c >= 17)}) begin
                errors++;
                $display("FAIL timeout c%0d: got ctl=%b trap=%0d cause=%0d expected trap=%0d",
                         c, w_ctl, trap_o, trap_cause_o, (c >= 17));
            end
            @(negedge clk);
        end
        mem_ready_i = 1'b1;
        pulse_reset();
    endtask

    task automatic test_ready_wins();
        opcode_i = T_RTYPE;
        for (int c = 1; c <= 19; c++) begin
            logic [6:0] exp;
            mem_ready_i = (c >= 16);
            exp = (c <= 15) ? 7'b1000000 : (c == 16) ? 7'b1100000 : (c == 19) ? 7'b0011100 : 7'b0;
            #1;
            checks++;
            if ({w_ctl, trap_o} !== {exp, 1'b0}) begin
                errors++;
                $display("FAIL ready_wins c%0d: got ctl=%b trap=%0d expected ctl=%b trap=0",
                         c, w_ctl, trap_o, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        opcode_i = T_RTYPE;
        mem_ready_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, ir_we_o} !== 2'b00) begin
            errors++;
            $display("FAIL midwait_drop: got req=%0d ir_we=%0d expected 0 0", mem_req_o, ir_we_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready_i = 1'b1;
        test_add();
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jal();
        test_illegal(T_BAD, 3'd0);
        test_illegal(T_STORE, 3'd3);
        test_timeout();
        test_ready_wins();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

endmodule
